ascii_2_byte: RTL
=================

Name: ascii_2_byte

Overview:
Receive-side counterpart of the hex-dump path. Takes ASCII characters from the UART RX, one strobe per character. Parses pairs of hex digits separated by space/CR/LF into bytes. Emits one byte strobe per complete pair, and flags malformed input so the downstream byte consumer only sees valid data.

Parameters:
TIMEOUT_CYC, 1000000, idle cycles between characters before a partial byte is abandoned; 0 disables the timeout
CNT_W, 20, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  input  1  system clock, all logic rising-edge
n_rst  input  1  asynchronous active-low reset
rx_data  input  8  ASCII character from UART RX, valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received character; back-to-back strobes allowed
byte_out  output  8  assembled byte; holds last value until next byte
byte_valid  output  1  one-cycle strobe, byte_out valid
err  output  1  one-cycle strobe on framing/character error
busy  output  1  high when state != S_IDLE

Behaviour:
- Reset (async, n_rst=0): state=S_IDLE, hi nibble=0, byte_out=8'h00, byte_valid=0, err=0, timeout counter=0. Reset mid-byte discards the partial nibble with no err.
- Character classes, evaluated only when rx_valid=1:
  - HEX: 0x30-0x39 gives value-0x30; 0x41-0x46 gives value-0x37.
  - SEP: 0x20, 0x0D, 0x0A.
  - BAD: everything else.
- States (2-bit): S_IDLE=00, S_HI=01, S_LO=10, S_ERR=11.
  - S_IDLE: HEX stores the high nibble and goes to S_HI. SEP stays. BAD pulses err and goes to S_ERR.
  - S_HI: HEX sets byte_out={hi,lo}, pulses byte_valid, goes to S_LO. SEP pulses err (lone digit) and goes to S_IDLE. BAD pulses err and goes to S_ERR.
  - S_LO: SEP goes to S_IDLE. HEX pulses err (third digit) and goes to S_ERR. BAD pulses err and goes to S_ERR.
  - S_ERR: discards input, no further err pulses. SEP goes to S_IDLE.
- Latency: byte_valid and err are registered and assert exactly 1 cycle after the rx_valid edge that caused them. byte_valid and err are never high in the same cycle.
- Timeout (TIMEOUT_CYC>0):
  - The counter clears on every rx_valid and whenever state=S_IDLE; otherwise it increments, saturating.
  - When it reaches TIMEOUT_CYC: in S_HI, pulse err and go to S_IDLE. In S_LO or S_ERR, go to S_IDLE silently.
  - If rx_valid arrives in the same cycle as expiry, rx_valid wins and the counter clears.
- No back-pressure: the consumer must accept byte_valid every cycle. The worst-case rate is one byte per 2 rx strobes.

Optional Feature:
ASCII2BYTE_LOWERCASE_EN
- Defined: 0x61-0x66 ('a'-'f') are class HEX with value-0x57. Mixed case within a pair is allowed.
- Undefined: 0x61-0x66 are BAD and produce err.

Decomposition:
- Shared package: state encodings, ASCII constants (ASCII_SPACE=8'h20, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0, ASCII_A, ASCII_a), and char-class encoding (CLS_HEX, CLS_SEP, CLS_BAD).
- One combinational sub-module, hex_char_decode: rx_data in; class and 4-bit nibble out. It contains the ASCII2BYTE_LOWERCASE_EN switch.
- FSM, timeout counter and output registers live in ascii_2_byte.

Test Plan:
1. Strobes '3','A',' ' -> byte_valid one cycle after the 'A' strobe, byte_out=0x3A, err never high, busy back to 0 after ' '.
2. Back-to-back strobes "FF\r\n00 " -> two byte_valid pulses with 0xFF then 0x00; CR and LF accepted as separators.
3. "G1 12 " -> err pulse after 'G'; '1' and ' ' discarded; then byte_out=0x12, exactly one err and one byte_valid total.
4. "123 45 " -> 0x12 strobe, err after '3', then 0x45. Also "7 " -> single err, no byte_valid.
5. TIMEOUT_CYC=16: '4', idle 16 cycles -> err pulse, state S_IDLE; then "56 " -> 0x56. Repeat with rx_valid landing on the expiry cycle -> no err, byte completes.
6. "ab " with macro defined -> 0xAB; without macro -> err after 'a', no byte. Assert n_rst after '9' mid-pair -> all outputs 0, then "9C " -> 0x9C.

Source files
------------

// File: rtl/ascii_2_byte_pkg.sv
// ascii_2_byte_pkg
// Shared types and constants for the ASCII hex-pair to byte parser:
// FSM state encoding, character-class encoding and the ASCII code points
// the parser cares about.
package ascii_2_byte_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_HI   = 2'b01,
      S_LO   = 2'b10,
      S_ERR  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      CLS_BAD = 2'b00,
      CLS_HEX = 2'b01,
      CLS_SEP = 2'b10
   } cls_t;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_F     = 8'h46;
   localparam logic [7:0] ASCII_a     = 8'h61;
   localparam logic [7:0] ASCII_f     = 8'h66;

endpackage

// File: rtl/ascii_2_byte_hex_char_decode.sv
// hex_char_decode
// Combinational classifier for one received ASCII character.
// Ports:
//   rx_data  in  8  ASCII character
//   cls      out    character class (CLS_HEX / CLS_SEP / CLS_BAD)
//   nibble   out 4  hex value, meaningful only when cls == CLS_HEX
// Build option: define ASCII2BYTE_LOWERCASE_EN to accept 'a'-'f' as hex
// digits; otherwise they classify as CLS_BAD.
module hex_char_decode
   import ascii_2_byte_pkg::*;
(
   input  logic [7:0] rx_data,
   output cls_t       cls,
   output logic [3:0] nibble
);

   always_comb begin
      cls    = CLS_BAD;
      nibble = 4'h0;
      if ((rx_data >= ASCII_0) && (rx_data <= ASCII_9)) begin
         cls    = CLS_HEX;
         nibble = rx_data[3:0];
      end else if ((rx_data >= ASCII_A) && (rx_data <= ASCII_F)) begin
         // 'A'..'F' have low nibbles 1..6, so +9 yields 0xA..0xF
         cls    = CLS_HEX;
         nibble = rx_data[3:0] + 4'd9;
`ifdef ASCII2BYTE_LOWERCASE_EN
      end else if ((rx_data >= ASCII_a) && (rx_data <= ASCII_f)) begin
         cls    = CLS_HEX;
         nibble = rx_data[3:0] + 4'd9;
`endif
      end else if ((rx_data == ASCII_SPACE) || (rx_data == ASCII_CR) ||
                   (rx_data == ASCII_LF)) begin
         cls = CLS_SEP;
      end
   end

endmodule

// File: rtl/ascii_2_byte.sv
// ascii_2_byte
// Parses separator-delimited pairs of ASCII hex digits from the UART RX
// into bytes. One byte_valid strobe per complete pair; malformed input
// produces a single err strobe and the rest of the token is discarded.
// Ports:
//   clk         in   1  system clock
//   n_rst       in   1  asynchronous active-low reset
//   rx_data     in   8  received ASCII character
//   rx_valid    in   1  one-cycle strobe per character
//   byte_out    out  8  last assembled byte
//   byte_valid  out  1  one-cycle strobe, byte_out updated
//   err         out  1  one-cycle strobe on framing/character error
//   busy        out  1  parser not idle
// Parameters: TIMEOUT_CYC (idle cycles before a partial token is dropped,
// 0 disables), CNT_W (counter width, 2^CNT_W > TIMEOUT_CYC).
// Build option: ASCII2BYTE_LOWERCASE_EN (see hex_char_decode).
//
// state  | meaning
// S_IDLE | between tokens, waiting for a first digit
// S_HI   | high nibble held, waiting for second digit
// S_LO   | byte emitted, waiting for separator
// S_ERR  | bad token, discarding until separator
module ascii_2_byte
   import ascii_2_byte_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1000000,
   parameter int CNT_W       = 20
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       err,
   output logic       busy
);

   cls_t             cls;
   logic [3:0]       nibble;
   state_t           state, state_nx;
   logic [3:0]       hi_q, hi_nx;
   logic [7:0]       byte_q, byte_nx;
   logic             bv_q, bv_nx;
   logic             err_q, err_nx;
   logic [CNT_W-1:0] cnt_q;
   logic             expire;

   hex_char_decode u_dec (
      .rx_data (rx_data),
      .cls     (cls),
      .nibble  (nibble)
   );

   assign expire = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else if (rx_valid || (state == S_IDLE)) begin
         cnt_q <= '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      hi_nx    = hi_q;
      byte_nx  = byte_q;
      bv_nx    = 1'b0;
      err_nx   = 1'b0;
      if (rx_valid) begin
         case (state)
            S_IDLE: begin
               if (cls == CLS_HEX) begin
                  hi_nx    = nibble;
                  state_nx = S_HI;
               end else if (cls == CLS_BAD) begin
                  err_nx   = 1'b1;
                  state_nx = S_ERR;
               end
            end
            S_HI: begin
               if (cls == CLS_HEX) begin
                  byte_nx  = {hi_q, nibble};
                  bv_nx    = 1'b1;
                  state_nx = S_LO;
               end else if (cls == CLS_SEP) begin
                  err_nx   = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  err_nx   = 1'b1;
                  state_nx = S_ERR;
               end
            end
            S_LO: begin
               if (cls == CLS_SEP) begin
                  state_nx = S_IDLE;
               end else begin
                  err_nx   = 1'b1;
                  state_nx = S_ERR;
               end
            end
            default: begin
               if (cls == CLS_SEP) begin
                  state_nx = S_IDLE;
               end
            end
         endcase
      end else if (expire) begin
         // only a lone high nibble is an error; a finished byte or an
         // already-flagged token just closes quietly
         if (state == S_HI) begin
            err_nx = 1'b1;
         end
         state_nx = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= S_IDLE;
         hi_q   <= 4'h0;
         byte_q <= 8'h00;
         bv_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         hi_q   <= hi_nx;
         byte_q <= byte_nx;
         bv_q   <= bv_nx;
         err_q  <= err_nx;
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = bv_q;
   assign err        = err_q;
   assign busy       = (state != S_IDLE);

endmodule
